// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter.
//   ramstate_t  : RAM port status as reported by the RAM model/controller
//   arb_state_t : arbiter grant state (who currently owns the RAM port)
//   DSTREAK_DEF : default number of back-to-back data grants while a fetch waits
//   TIMEOUT_DEF : default busy-cycle budget before a transaction is aborted
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } arb_state_t;

   localparam int DSTREAK_DEF = 4;
   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between the datapath/cache side, the arbiter and RAM.
//   slave  : the arbiter's view (takes requests and RAM status, drives hits,
//            load data, RAM enables/address/store data and err)
//   master : the environment's view (datapath requesters plus the RAM itself)
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W = 32
);
   // instruction-fetch path
   logic              iREN;
   logic [DATA_W-1:0] iaddr;
   logic [DATA_W-1:0] iload;
   logic              ihit;
   // data-access path
   logic              dREN;
   logic              dWEN;
   logic [DATA_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic [DATA_W-1:0] dload;
   logic              dhit;
   // shared RAM port
   logic              ramREN;
   logic              ramWEN;
   logic [DATA_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic [DATA_W-1:0] ramload;
   ramstate_t         ramstate;
   // abort indication
   logic              err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter_timeout_counter.sv
// Busy-cycle counter that bounds how long one RAM transaction may take.
//   CLK, RST : clock, asynchronous active-high reset
//   clr_i    : hold the count at zero (arbiter idle)
//   en_i     : count this cycle (busy and no completion)
//   expire_o : count has reached TIMEOUT-1
module arb_timeout_counter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] tcnt_q, tcnt_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      tcnt_d = tcnt_q;
      if (clr_i)     tcnt_d = '0;
      else if (en_i) tcnt_d = tcnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) tcnt_q <= '0;
      else     tcnt_q <= tcnt_d;
   end

   assign expire_o = (tcnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for one shared RAM port between instruction fetch and data access.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave view of mem_arbiter_if (requests, hits, RAM port, err)
// The registered grant state decodes straight into the RAM controls, so an
// asynchronous reset drops the enables without waiting for a clock edge.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DSTREAK_MAX = DSTREAK_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.slave  bus
);
   localparam int                  STREAK_W   = $clog2(DSTREAK_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(DSTREAK_MAX);

   arb_state_t          state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;

   logic d_req, busy, owner_req, ram_acc, ram_err, owner_drop, expire, fetch_starved;

   assign d_req         = bus.dREN | bus.dWEN;
   assign busy          = (state_q != IDLE);
   assign ram_acc       = busy && (bus.ramstate == ACCESS);
   assign ram_err       = busy && (bus.ramstate == ERROR);
   assign owner_drop    = busy && !owner_req;
   // A fetch that has watched DSTREAK_MAX data grants go by wins the next slot.
   assign fetch_starved = bus.iREN && (streak_q == STREAK_CAP);

   always_comb begin
      case (state_q)
         IBUSY:   owner_req = bus.iREN;
         DBUSY:   owner_req = d_req;
         default: owner_req = 1'b0;
      endcase
   end

   arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .CLK      (CLK),
      .RST      (RST),
      .clr_i    (!busy),
      .en_i     (busy && !ram_acc && !ram_err),
      .expire_o (expire)
   );

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      case (state_q)
         IDLE: begin
            if (d_req && !fetch_starved) begin
               state_d = DBUSY;
               // Streak only counts data grants that overtook a waiting fetch.
               if (!bus.iREN)                  streak_d = '0;
               else if (streak_q != STREAK_CAP) streak_d = streak_q + 1'b1;
            end else if (bus.iREN) begin
               state_d  = IBUSY;
               streak_d = '0;
            end
         end
         default: begin
            // Any terminating event ends the transaction; which one only
            // matters for the hit/err outputs below.
            if (ram_err || ram_acc || owner_drop || expire) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = {DATA_W{1'b0}};
      bus.ramstore = {DATA_W{1'b0}};
      bus.ihit     = 1'b0;
      bus.dhit     = 1'b0;
      bus.iload    = {DATA_W{1'b0}};
      bus.dload    = {DATA_W{1'b0}};
      case (state_q)
         IBUSY: begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
            bus.ihit    = ram_acc;
            if (ram_acc) bus.iload = bus.ramload;
         end
         DBUSY: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            // A write request takes precedence if both are raised.
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN && !bus.dWEN;
            bus.dhit     = ram_acc;
            if (ram_acc) bus.dload = bus.ramload;
         end
         default: ;
      endcase
      // ERROR beats ACCESS (mutually exclusive anyway); a dropped request
      // aborts quietly even on the timeout cycle.
      bus.err = ram_err || (busy && expire && !ram_acc && !owner_drop);
   end

endmodule
